// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The flags signal exists only when FP_MUL_FLAGS_EN is defined.
interface fp_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] num1;
   logic [W-1:0] num2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]   flags;
`endif

   // master: operand producer / result consumer; slave: the multiplier
   modport master (
      output in_valid, num1, num2, out_ready,
      input  in_ready, out_valid, result
`ifdef FP_MUL_FLAGS_EN
      , input flags
`endif
   );

   modport slave (
      input  in_valid, num1, num2, out_ready,
      output in_ready, out_valid, result
`ifdef FP_MUL_FLAGS_EN
      , output flags
`endif
   );
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: classify -> multiply -> normalise/round -> pack.
// Optional FP_MUL_FLAGS_EN adds the registered {invalid, overflow, underflow, inexact} flags.
module fp_mul_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic         clk,
   input  logic         rstn,
   fp_mul_pipe_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int ESW = EXP_W + 2;
   localparam int PW  = 2 * MAN_W + 2;
   localparam logic [ESW-1:0] BIAS = ESW'((1 << (EXP_W - 1)) - 1);
   localparam logic [ESW-2:0] MAXE = (ESW-1)'((1 << EXP_W) - 1);

   typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

   logic adv;
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   // ---------------- stage 1: unpack / classify ----------------
   logic [EXP_W-1:0] e1, e2;
   logic [MAN_W-1:0] f1, f2;
   logic             z1, z2, i1, i2, n1, n2;
   kind_t            kind_c;
   logic             inv_c;
   logic [ESW-1:0]   es_c;

   assign e1 = bus.num1[MAN_W +: EXP_W];
   assign e2 = bus.num2[MAN_W +: EXP_W];
   assign f1 = bus.num1[MAN_W-1:0];
   assign f2 = bus.num2[MAN_W-1:0];
   assign z1 = (e1 == '0);
   assign z2 = (e2 == '0);
   assign i1 = (e1 == '1) && (f1 == '0);
   assign i2 = (e2 == '1) && (f2 == '0);
   assign n1 = (e1 == '1) && (f1 != '0);
   assign n2 = (e2 == '1) && (f2 != '0);
   assign es_c = ESW'({2'b00, e1}) + ESW'({2'b00, e2}) - BIAS;

   always_comb begin
      inv_c  = (i1 && z2) || (z1 && i2);
      kind_c = K_NORM;
      if (n1 || n2 || inv_c) kind_c = K_NAN;
      else if (i1 || i2)     kind_c = K_INF;
      else if (z1 || z2)     kind_c = K_ZERO;
   end

   logic                  v1, sign1;
   kind_t                 kind1;
   logic signed [ESW-1:0] es1;
   logic [MAN_W:0]        ma1, mb1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1    <= 1'b0;
         sign1 <= 1'b0;
         kind1 <= K_NORM;
         es1   <= '0;
         ma1   <= '0;
         mb1   <= '0;
      end else if (adv) begin
         v1    <= bus.in_valid;
         sign1 <= bus.num1[W-1] ^ bus.num2[W-1];
         kind1 <= kind_c;
         es1   <= es_c;
         ma1   <= {1'b1, f1};
         mb1   <= {1'b1, f2};
      end
   end

   // ---------------- stage 2: mantissa multiply ----------------
   logic                  v2, sign2;
   kind_t                 kind2;
   logic signed [ESW-1:0] es2;
   logic [PW-1:0]         prod2;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v2    <= 1'b0;
         sign2 <= 1'b0;
         kind2 <= K_NORM;
         es2   <= '0;
         prod2 <= '0;
      end else if (adv) begin
         v2    <= v1;
         sign2 <= sign1;
         kind2 <= kind1;
         es2   <= es1;
         prod2 <= ma1 * mb1;
      end
   end

   // ---------------- stage 3: normalise / round ----------------
   logic               msb, drop, guard, sticky, rnd;
   logic [2*MAN_W-1:0] pn;
   logic [MAN_W-1:0]   frac_t;
   logic [MAN_W:0]     frac_r;
   logic [ESW-1:0]     es_n;

   // pn drops the leading one; a right shift pushes prod2[0] into sticky
   assign msb    = prod2[PW-1];
   assign pn     = msb ? prod2[PW-2:1] : prod2[PW-3:0];
   assign drop   = msb & prod2[0];
   assign frac_t = pn[2*MAN_W-1:MAN_W];
   assign guard  = pn[MAN_W-1];
   assign sticky = (|pn[MAN_W-2:0]) | drop;
   assign rnd    = guard & (sticky | frac_t[0]);
   assign frac_r = {1'b0, frac_t} + (MAN_W+1)'(rnd);
   assign es_n   = es2 + ESW'(msb) + ESW'(frac_r[MAN_W]);

   logic                  v3, sign3;
   kind_t                 kind3;
   logic signed [ESW-1:0] es3;
   logic [MAN_W-1:0]      frac3;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v3    <= 1'b0;
         sign3 <= 1'b0;
         kind3 <= K_NORM;
         es3   <= '0;
         frac3 <= '0;
      end else if (adv) begin
         v3    <= v2;
         sign3 <= sign2;
         kind3 <= kind2;
         es3   <= es_n;
         frac3 <= frac_r[MAN_W-1:0];
      end
   end

`ifdef FP_MUL_FLAGS_EN
   logic inv1, inv2, inv3, inex3;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         inv1  <= 1'b0;
         inv2  <= 1'b0;
         inv3  <= 1'b0;
         inex3 <= 1'b0;
      end else if (adv) begin
         inv1  <= inv_c;
         inv2  <= inv1;
         inv3  <= inv2;
         inex3 <= guard | sticky;
      end
   end
`endif

   // ---------------- pack / output register ----------------
   logic         ovf, unf;
   logic [W-1:0] res_c;
   logic [3:0]   flags_c;

   assign ovf = !es3[ESW-1] && (es3[ESW-2:0] >= MAXE);
   assign unf = es3[ESW-1] || (es3 == '0);

   always_comb begin
      res_c   = '0;
      flags_c = '0;
      unique case (kind3)
         K_NAN: begin
            res_c = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
            flags_c[3] = inv3;
`endif
         end
         K_INF:  res_c = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         K_ZERO: res_c = {sign3, {(W-1){1'b0}}};
         default: begin
            if (ovf) begin
               res_c   = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_c = 4'b0101;
            end else if (unf) begin
               res_c   = {sign3, {(W-1){1'b0}}};
               flags_c = 4'b0011;
            end else begin
               res_c = {sign3, es3[EXP_W-1:0], frac3};
`ifdef FP_MUL_FLAGS_EN
               flags_c[0] = inex3;
`endif
            end
         end
      endcase
   end

   logic         out_valid_q;
   logic [W-1:0] result_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (adv) begin
         out_valid_q <= v3;
         result_q    <= res_c;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

`ifdef FP_MUL_FLAGS_EN
   logic [3:0] flags_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)    flags_q <= '0;
      else if (adv) flags_q <= flags_c;
   end

   assign bus.flags = flags_q;
`else
   logic unused_flags;
   assign unused_flags = ^flags_c;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe: single precision with backpressure and reset, plus a half-precision instance.
module tb_fp_mul_pipe;
   logic clk = 1'b0;
   logic rstn;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   rand_rdy = 1'b0;

   always #5 clk = ~clk;

   fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus_s ();
   fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus_h ();

   fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) u_dut  (.clk(clk), .rstn(rstn), .bus(bus_s));
   fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_half (.clk(clk), .rstn(rstn), .bus(bus_h));

   typedef struct {
      logic [31:0] res;
      logic [3:0]  fl;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t sb[$];

   localparam int NV = 12;
   logic [31:0] va [NV];
   logic [31:0] vb [NV];
   logic [31:0] vr [NV];
   logic [3:0]  vf [NV];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      bus_s.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: handshake rule, stall hold, in-order scoreboard compare
   initial begin : monitor
      bit          prev_stall;
      logic [31:0] prev_res;
      exp_t        e;
      prev_stall = 1'b0;
      prev_res   = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_stall = 1'b0;
         end else begin
            check_val("in_ready", 32'(bus_s.in_ready), 32'(!bus_s.out_valid || bus_s.out_ready));
            if (prev_stall) check_val("stall_hold", bus_s.result, prev_res);
            if (bus_s.out_valid && bus_s.out_ready) begin
               if (sb.size() == 0) begin
                  check_val("unexpected_out", 32'(bus_s.out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check_val("result", bus_s.result, e.res);
`ifdef FP_MUL_FLAGS_EN
                  check_val("flags", 32'(bus_s.flags), 32'(e.fl));
`endif
                  if (e.lat) check_val("latency", 32'(cyc - e.acc), 32'd3);
               end
            end
            prev_stall = bus_s.out_valid && !bus_s.out_ready;
            prev_res   = bus_s.result;
         end
      end
   end

   task automatic send(input int i, input bit lat, input bit push);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      bus_s.in_valid = 1'b1;
      bus_s.num1     = va[i];
      bus_s.num2     = vb[i];
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus_s.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_val("in_ready_timeout", 32'(bus_s.in_ready), 32'd1);
      @(posedge clk);
      #1;
      e.res = vr[i];
      e.fl  = vf[i];
      e.acc = cyc;
      e.lat = lat;
      if (push) sb.push_back(e);
      bus_s.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check_val("drain", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic half_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r, input logic [3:0] f);
      bus_h.in_valid = 1'b1;
      bus_h.num1     = a;
      bus_h.num2     = b;
      @(posedge clk);
      #1;
      bus_h.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_val("half_early", 32'(bus_h.out_valid), 32'd0);
      @(posedge clk);
      #1;
      check_val("half_valid", 32'(bus_h.out_valid), 32'd1);
      check_val("half_result", 32'(bus_h.result), 32'(r));
`ifdef FP_MUL_FLAGS_EN
      check_val("half_flags", 32'(bus_h.flags), 32'(f));
`else
      if (f === 4'hx) $display("unreachable");
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      va = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F800000, 32'hFF800000, 32'h7FC00001,
             32'h7F000000, 32'h00800000, 32'h40400000, 32'h40A00000, 32'h3FC00001, 32'h3F800001};
      vb = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h00000000, 32'h40000000, 32'h3F800000,
             32'h7F000000, 32'h3F000000, 32'h40400000, 32'h3E800000, 32'h3FC00000, 32'h3FC00000};
      vr = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h7FC00000, 32'hFF800000, 32'h7FC00000,
             32'h7F800000, 32'h00000000, 32'h41100000, 32'h3FA00000, 32'h40100001, 32'h3FC00002};
      vf = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h0, 4'h0, 4'h5, 4'h3, 4'h0, 4'h0, 4'h1, 4'h1};

      rstn            = 1'b0;
      bus_s.in_valid  = 1'b0;
      bus_s.num1      = '0;
      bus_s.num2      = '0;
      bus_s.out_ready = 1'b1;
      bus_h.in_valid  = 1'b0;
      bus_h.num1      = '0;
      bus_h.num2      = '0;
      bus_h.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", 32'(bus_s.out_valid), 32'd0);
      check_val("rst_result", bus_s.result, 32'd0);
      check_val("rst_in_ready", 32'(bus_s.in_ready), 32'd1);
`ifdef FP_MUL_FLAGS_EN
      check_val("rst_flags", 32'(bus_s.flags), 32'd0);
`endif
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // directed vectors, one at a time, latency checked
      for (int i = 0; i < NV; i++) begin
         send(i, 1'b1, 1'b1);
         drain();
      end

      // back-to-back stream under random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < NV; i++) send(i, 1'b0, 1'b1);
      drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) send(i, 1'b0, 1'b0);
      rstn = 1'b0;
      #1;
      check_val("rst_mid_valid", 32'(bus_s.out_valid), 32'd0);
      check_val("rst_mid_result", bus_s.result, 32'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check_val("post_rst_idle", 32'(bus_s.out_valid), 32'd0);
      send(8, 1'b1, 1'b1);
      drain();

      // half precision instance
      half_op(16'h3E00, 16'h4000, 16'h4200, 4'h0);
      half_op(16'h7800, 16'h7800, 16'h7C00, 4'h5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
